// File: rtl/fsk_symbol_rx_if.sv
// fsk_symbol_rx_if: sample-side and result-side signals of the FSK symbol receiver.
//   SAMP      sample strobe, one-cycle pulse per sample
//   ALIGN     symbol-boundary marker, only meaningful together with SAMP
//   RX_REAL   real sign bit of the 1-bit I/Q stream
//   RX_IMAG   imaginary sign bit of the 1-bit I/Q stream
//   ROT       signed net quarter turns measured over the last symbol
//   ROT_VALID one-cycle pulse when ROT updates
//   LOCKED    ALIGN tracking established
//   ERR_CNT   saturating count of half-turn (ambiguous) transitions
// master = sample source / result consumer, slave = the receiver.
interface fsk_symbol_rx_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
);
  logic                    SAMP;
  logic                    ALIGN;
  logic                    RX_REAL;
  logic                    RX_IMAG;
  logic signed [CNT_W-1:0] ROT;
  logic                    ROT_VALID;
  logic                    LOCKED;
  logic [ERR_W-1:0]        ERR_CNT;

  modport master (
    output SAMP, ALIGN, RX_REAL, RX_IMAG,
    input  ROT, ROT_VALID, LOCKED, ERR_CNT
  );

  modport slave (
    input  SAMP, ALIGN, RX_REAL, RX_IMAG,
    output ROT, ROT_VALID, LOCKED, ERR_CNT
  );
endinterface

// File: rtl/fsk_symbol_rx.sv
// fsk_symbol_rx: measures net phase rotation of a 1-bit I/Q stream in quarter
// turns over each symbol and reports it as a signed tone value, while tracking
// the symbol boundary marker.
//   CLOCK  system clock
//   RESET  asynchronous active-high reset
//   bus    fsk_symbol_rx_if slave modport (sample inputs, rotation results)
module fsk_symbol_rx #(
  parameter int SYMB_LEN = 128,
  parameter int CNT_W    = 8,
  parameter int ERR_W    = 8
) (
  input  logic            CLOCK,
  input  logic            RESET,
  fsk_symbol_rx_if.slave  bus
);

  localparam int CW = (SYMB_LEN > 2) ? $clog2(SYMB_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(SYMB_LEN - 1);
  // Symmetric saturation limits so a tone and its mirror report equal magnitude.
  localparam logic signed [CNT_W:0] ACC_MAX = $signed({2'b00, {(CNT_W-1){1'b1}}});
  localparam logic signed [CNT_W:0] ACC_MIN = -ACC_MAX;

  typedef enum logic [1:0] {IDLE, HUNT, LOCK} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              q_prev_q, q_prev_d;
  logic signed [CNT_W-1:0] acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [CNT_W-1:0] rot_q, rot_d;
  logic                    rot_valid_q, rot_valid_d;
  logic [ERR_W-1:0]        err_q, err_d;

  logic [1:0]              q_cur;
  logic [1:0]              diff;
  logic signed [CNT_W:0]   step;
  logic signed [CNT_W:0]   sum;
  logic signed [CNT_W:0]   sum_sat;
  logic                    at_last;
  logic                    boundary;

  always_comb begin
    // Gray-ordered quadrant index so one quarter turn changes q by exactly 1.
    case ({bus.RX_REAL, bus.RX_IMAG})
      2'b10:   q_cur = 2'd0;
      2'b11:   q_cur = 2'd1;
      2'b01:   q_cur = 2'd2;
      default: q_cur = 2'd3;
    endcase

    diff = q_cur - q_prev_q;
    case (diff)
      2'd1:    step = (CNT_W+1)'(1);
      2'd3:    step = -(CNT_W+1)'(1);
      default: step = '0;
    endcase

    sum = {acc_q[CNT_W-1], acc_q} + step;
    if (sum > ACC_MAX)      sum_sat = ACC_MAX;
    else if (sum < ACC_MIN) sum_sat = ACC_MIN;
    else                    sum_sat = sum;

    at_last  = (cnt_q == LAST);
    boundary = at_last || bus.ALIGN;

    state_d     = state_q;
    q_prev_d    = q_prev_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    rot_d       = rot_q;
    rot_valid_d = 1'b0;
    err_d       = err_q;

    if (bus.SAMP) begin
      q_prev_d = q_cur;
      case (state_q)
        IDLE: begin
          // First sample only provides a phase reference.
          state_d = HUNT;
        end
        HUNT, LOCK: begin
          // A half turn has no defined direction: count it, contribute nothing.
          if (diff == 2'd2 && err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + ERR_W'(1);
          end
          if (boundary) begin
            rot_d       = sum_sat[CNT_W-1:0];
            rot_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            acc_d = sum_sat[CNT_W-1:0];
            cnt_d = cnt_q + CW'(1);
          end
          if (state_q == HUNT) begin
            if (bus.ALIGN) state_d = LOCK;
          end else if (bus.ALIGN != at_last) begin
            // Marker and free-running count disagree: tracking lost.
            state_d = HUNT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      q_prev_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      rot_q       <= '0;
      rot_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      q_prev_q    <= q_prev_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      rot_q       <= rot_d;
      rot_valid_q <= rot_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.ROT       = rot_q;
  assign bus.ROT_VALID = rot_valid_q;
  assign bus.LOCKED    = (state_q == LOCK);
  assign bus.ERR_CNT   = err_q;

endmodule

// File: tb/tb_fsk_symbol_rx.sv
// tb_fsk_symbol_rx: scenario tasks drive I/Q samples and push the expected
// rotation of every symbol into a queue; a negedge monitor pops and compares
// on each ROT_VALID.
module tb_fsk_symbol_rx;

  logic CLOCK = 1'b0;
  logic RESET;

  fsk_symbol_rx_if #(.CNT_W(8), .ERR_W(8)) bus ();

  fsk_symbol_rx #(.SYMB_LEN(128), .CNT_W(8), .ERR_W(8)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];
  int q_cur = 0;

  // Scoreboard consumer: every ROT_VALID must match the oldest expected value.
  always @(negedge CLOCK) begin
    if (bus.ROT_VALID === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL rot_unexpected: got ROT_VALID with ROT=%0d, none expected", bus.ROT);
      end else begin
        logic signed [7:0] e8;
        e8 = 8'(exp_q.pop_front());
        if (bus.ROT !== e8) $display("FAIL rot_value: got %0d expected %0d", bus.ROT, e8);
        else begin
          n_pass++;
          $display("rot_valid: ROT=%0d ok", bus.ROT);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One SAMP with quadrant q; consecutive calls give back-to-back strobes.
  task automatic samp(input int q, input bit align);
    case (q & 3)
      0:       begin bus.RX_REAL = 1'b1; bus.RX_IMAG = 1'b0; end
      1:       begin bus.RX_REAL = 1'b1; bus.RX_IMAG = 1'b1; end
      2:       begin bus.RX_REAL = 1'b0; bus.RX_IMAG = 1'b1; end
      default: begin bus.RX_REAL = 1'b0; bus.RX_IMAG = 1'b0; end
    endcase
    bus.SAMP  = 1'b1;
    bus.ALIGN = align;
    @(posedge CLOCK);
    #1;
    bus.SAMP  = 1'b0;
    bus.ALIGN = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset;
    bus.SAMP = 1'b0; bus.ALIGN = 1'b0; bus.RX_REAL = 1'b0; bus.RX_IMAG = 1'b0;
    RESET = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    idle(1);
    n_total++; if (bus.ROT !== 8'sd0) $display("FAIL reset_rot: got %0d expected 0", bus.ROT); else n_pass++;
    n_total++; if (bus.ROT_VALID !== 1'b0) $display("FAIL reset_rot_valid: got %b expected 0", bus.ROT_VALID); else n_pass++;
    n_total++; if (bus.LOCKED !== 1'b0) $display("FAIL reset_locked: got %b expected 0", bus.LOCKED); else n_pass++;
    n_total++; if (bus.ERR_CNT !== 8'd0) $display("FAIL reset_err_cnt: got %0d expected 0", bus.ERR_CNT); else n_pass++;
    $display("test_reset done");
  endtask

  // +1 quarter turn every sample: 128 turns saturate to +127.
  task automatic test_saturation;
    q_cur = 0;
    samp(q_cur, 1'b0);
    for (int j = 0; j < 128; j++) begin
      q_cur = q_cur + 1;
      if (j == 127) exp_q.push_back(127);
      samp(q_cur, 1'b0);
    end
    idle(2);
    n_total++; if (exp_q.size() != 0) begin $display("FAIL sat_pending: %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end else n_pass++;
    n_total++; if (bus.LOCKED !== 1'b0) $display("FAIL sat_locked: got %b expected 0", bus.LOCKED); else n_pass++;
    n_total++; if (bus.ERR_CNT !== 8'd0) $display("FAIL sat_err_cnt: got %0d expected 0", bus.ERR_CNT); else n_pass++;
    $display("test_saturation done");
  endtask

  // -1 every 4th sample, ALIGN on each 128th sample, three symbols.
  task automatic test_lock;
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 128; j++) begin
        if (j % 4 == 3) q_cur = q_cur - 1;
        if (j == 127) exp_q.push_back(-32);
        samp(q_cur, j == 127);
        if (s == 0 && j == 126) begin
          n_total++; if (bus.LOCKED !== 1'b0) $display("FAIL lock_before_align: got %b expected 0", bus.LOCKED); else n_pass++;
        end
      end
      n_total++; if (bus.LOCKED !== 1'b1) $display("FAIL lock_after_symbol%0d: got %b expected 1", s, bus.LOCKED); else n_pass++;
    end
    idle(2);
    n_total++; if (exp_q.size() != 0) begin $display("FAIL lock_pending: %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end else n_pass++;
    $display("test_lock done");
  endtask

  // Early ALIGN while locked forces a boundary and drops lock; counter restarts.
  task automatic test_align_early;
    for (int j = 0; j <= 60; j++) begin
      if (j % 2 == 1) q_cur = q_cur + 1;
      if (j == 60) exp_q.push_back(30);
      samp(q_cur, j == 60);
    end
    n_total++; if (bus.LOCKED !== 1'b0) $display("FAIL early_locked: got %b expected 0", bus.LOCKED); else n_pass++;
    for (int j = 0; j < 128; j++) begin
      if (j == 127) exp_q.push_back(0);
      samp(q_cur, j == 127);
    end
    n_total++; if (bus.LOCKED !== 1'b1) $display("FAIL early_relock: got %b expected 1", bus.LOCKED); else n_pass++;
    idle(2);
    n_total++; if (exp_q.size() != 0) begin $display("FAIL early_pending: %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end else n_pass++;
    $display("test_align_early done");
  endtask

  // Missing ALIGN at the end of a locked symbol: result still emitted, lock lost.
  task automatic test_drop_align;
    for (int j = 0; j < 128; j++) begin
      if (j % 2 == 1) q_cur = q_cur - 1;
      if (j == 127) exp_q.push_back(-64);
      samp(q_cur, 1'b0);
      if (j == 126) begin
        n_total++; if (bus.LOCKED !== 1'b1) $display("FAIL drop_locked_before: got %b expected 1", bus.LOCKED); else n_pass++;
      end
    end
    n_total++; if (bus.LOCKED !== 1'b0) $display("FAIL drop_locked_after: got %b expected 0", bus.LOCKED); else n_pass++;
    idle(2);
    n_total++; if (exp_q.size() != 0) begin $display("FAIL drop_pending: %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end else n_pass++;
    $display("test_drop_align done");
  endtask

  // Half turns every sample: zero rotation, error counter saturates at 255.
  task automatic test_errors;
    for (int j = 0; j < 300; j++) begin
      q_cur = q_cur + 2;
      if (j == 127 || j == 255) exp_q.push_back(0);
      samp(q_cur, 1'b0);
      if (j == 99) begin
        n_total++; if (bus.ERR_CNT !== 8'd100) $display("FAIL err_cnt_mid: got %0d expected 100", bus.ERR_CNT); else n_pass++;
      end
    end
    n_total++; if (bus.ERR_CNT !== 8'd255) $display("FAIL err_cnt_sat: got %0d expected 255", bus.ERR_CNT); else n_pass++;
    idle(2);
    n_total++; if (exp_q.size() != 0) begin $display("FAIL err_pending: %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end else n_pass++;
    $display("test_errors done");
  endtask

  // Async reset in the middle of a locked +1/sample symbol.
  task automatic test_reset_mid;
    q_cur = q_cur + 1;
    exp_q.push_back(1);
    samp(q_cur, 1'b1);
    for (int j = 0; j < 50; j++) begin
      q_cur = q_cur + 1;
      samp(q_cur, 1'b0);
    end
    n_total++; if (bus.LOCKED !== 1'b1) $display("FAIL rstmid_locked_before: got %b expected 1", bus.LOCKED); else n_pass++;
    n_total++; if (bus.ROT !== 8'sd1) $display("FAIL rstmid_rot_before: got %0d expected 1", bus.ROT); else n_pass++;
    // Sample 50 is on the bus when reset hits, before its clock edge.
    q_cur = q_cur + 1;
    bus.RX_REAL = 1'b1; bus.RX_IMAG = 1'b0;
    bus.SAMP = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    n_total++; if (bus.ROT !== 8'sd0) $display("FAIL rstmid_rot: got %0d expected 0", bus.ROT); else n_pass++;
    n_total++; if (bus.ROT_VALID !== 1'b0) $display("FAIL rstmid_rot_valid: got %b expected 0", bus.ROT_VALID); else n_pass++;
    n_total++; if (bus.LOCKED !== 1'b0) $display("FAIL rstmid_locked: got %b expected 0", bus.LOCKED); else n_pass++;
    n_total++; if (bus.ERR_CNT !== 8'd0) $display("FAIL rstmid_err_cnt: got %0d expected 0", bus.ERR_CNT); else n_pass++;
    bus.SAMP = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    idle(3);
    n_total++; if (exp_q.size() != 0) begin $display("FAIL rstmid_pending: %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end else n_pass++;
    samp(q_cur, 1'b0);
    for (int j = 0; j < 128; j++) begin
      q_cur = q_cur + 1;
      if (j == 127) exp_q.push_back(127);
      samp(q_cur, 1'b0);
    end
    idle(2);
    n_total++; if (exp_q.size() != 0) begin $display("FAIL rstmid_final_pending: %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end else n_pass++;
    n_total++; if (bus.LOCKED !== 1'b0) $display("FAIL rstmid_final_locked: got %b expected 0", bus.LOCKED); else n_pass++;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_lock();
    test_align_early();
    test_drop_align();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
